hc_sr04_array: RTL
==================

# hc_sr04_array

Multi-channel controller for up to CHANNELS HC-SR04 ultrasonic rangers sharing one measurement engine. On a start pulse, or continuously, it sweeps the enabled sensors in round-robin order: it triggers one sensor, times its echo, reports the result, then waits a holdoff before the next sensor to avoid acoustic crosstalk. It adds echo synchronisation, no-echo timeout, echo-length saturation and per-channel enables, none of which the single-sensor interface has. It sits between the sensor pins (through 5V level shifters) and the system's distance-consumer logic.

## Interface
- CHANNELS, 4: number of sensors, 1 to 16.
- TRIG_CYCLES, 1000: trigger pulse width in clk cycles (10 us at 100 MHz).
- TIMEOUT_CYCLES, 3_000_000: maximum wait for echo rise after trigger (30 ms).
- MAX_ECHO_CYCLES, 2_500_000: echo length at which counting saturates (25 ms, about 4.3 m).
- HOLDOFF_CYCLES, 6_000_000: idle gap after each measurement (60 ms).
- CNT_W, 22: result count width; must hold MAX_ECHO_CYCLES.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request for a single sweep; ignored while busy.
- continuous  in  1  1 = begin a new sweep automatically after each sweep.
- ch_enable  in  CHANNELS  per-sensor enable, latched at sweep start.
- echo  in  CHANNELS  raw echo inputs, asynchronous.
- trig  out  CHANNELS  trigger outputs; at most one bit high at a time.
- busy  out  1  high from sweep start until return to IDLE.
- result_valid  out  1  one-cycle pulse per completed measurement.
- result_ch  out  clog2(CHANNELS), min 1  channel of the current result.
- result_count  out  CNT_W  echo high time in clk cycles.
- result_timeout  out  1  1 = no echo, or echo saturated.

## Operation
- Each echo bit passes through a 2-FF synchroniser (echo_s). All echo decisions use echo_s.
- FSM states: IDLE, TRIGGER, WAIT_ECHO, COUNT, HOLDOFF.
- IDLE: a sweep starts when (start | continuous) and the latched-at-this-cycle ch_enable is nonzero.
  - On start, en_q <= ch_enable and ch <= lowest set index. Then go to TRIGGER.
  - If ch_enable is 0, the FSM stays in IDLE and busy stays 0.
- TRIGGER: trig[ch] is high. A cycle counter runs; after TRIG_CYCLES cycles the FSM enters WAIT_ECHO.
- WAIT_ECHO: a timeout counter runs.
  - If echo_s[ch] is high, the FSM enters COUNT.
  - If the counter reaches TIMEOUT_CYCLES first, the FSM emits a result with count 0 and timeout 1, then enters HOLDOFF.
- COUNT: count increments each cycle that echo_s[ch] is high.
  - When echo_s[ch] falls, the FSM emits the result with timeout 0.
  - If count reaches MAX_ECHO_CYCLES, the FSM emits count = MAX_ECHO_CYCLES with timeout 1, without waiting for echo to fall.
- HOLDOFF: waits HOLDOFF_CYCLES cycles, then advances ch to the next higher set bit in en_q.
  - If there is no higher set bit, the sweep is complete.
  - On completion with continuous=1: re-latch en_q from ch_enable, restart from the lowest set bit, and go to TRIGGER. If the new enable mask is 0, go to IDLE.
  - On completion with continuous=0: go to IDLE.
- continuous deasserted mid-sweep: the current sweep finishes, then the FSM goes to IDLE.
- Counters never wrap. They clear on every state entry.

## Timing
- Reset values: state IDLE, trig all 0, busy 0, result_valid 0, result_ch 0, result_count 0, result_timeout 0, synchronisers 0.
- Reset mid-operation: trig drops asynchronously, and all in-flight results are discarded.
- busy rises the cycle after start is sampled, and falls on the cycle IDLE is entered.
- trig[ch] is high for exactly TRIG_CYCLES consecutive cycles.
- result_count equals the number of cycles echo_s was high, which equals the raw echo width in cycles.
- result_valid pulses the cycle after the falling edge is seen on echo_s. This is 3 cycles after the raw echo falls.
- result_ch, result_count and result_timeout hold their values until the next result_valid.
- A start pulse coincident with the return to IDLE is ignored. The start must be sampled while already in IDLE.
- Sweep period per enabled channel, excluding echo time: TRIG_CYCLES + HOLDOFF_CYCLES plus about 3 cycles of FSM overhead.

## Test plan
Bench parameters: CHANNELS=4, TRIG_CYCLES=10, TIMEOUT_CYCLES=100, MAX_ECHO_CYCLES=200, HOLDOFF_CYCLES=20.
- Single echo: ch_enable=4'b0001, start pulse, echo[0] high 50 cycles starting 30 cycles after trig falls -> trig[0] high 10 cycles; one result_valid with ch=0, count=50, timeout=0; busy returns to 0.
- Round-robin sweep: ch_enable=4'b1010, echo widths 40 and 60 -> results in order (ch=1, count=40) then (ch=3, count=60); trig[0] and trig[2] never assert; at most one trig bit high at any time.
- Timeout: ch_enable=4'b0100, echo[2] held low -> result ch=2, count=0, timeout=1, emitted 100 cycles after WAIT_ECHO entry.
- Saturation: echo[0] held high 500 cycles -> count=200, timeout=1; the next channel triggers only after holdoff.
- Continuous mode: continuous=1, ch_enable=4'b0011, echo widths 25 each -> repeated results ch0, ch1, ch0, ...; after continuous drops, the current sweep ends and busy falls.
- Reset mid-COUNT: assert rst during an echo -> trig=0, busy=0 and no result_valid pulse; a fresh start then measures correctly.

Source files
------------

// File: rtl/hc_sr04_array.sv
`default_nettype none
// ============================================================================
// Module  : hc_sr04_array
// Brief   : Round-robin trigger/echo-timing engine shared by several HC-SR04s
// Revision: 1.0
// ============================================================================
module hc_sr04_array #(
    parameter int CHANNELS        = 4,
    parameter int TRIG_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES  = 3_000_000,
    parameter int MAX_ECHO_CYCLES = 2_500_000,
    parameter int HOLDOFF_CYCLES  = 6_000_000,
    parameter int CNT_W           = 22,
    localparam int c_ch_w         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                continuous,
    input  logic [CHANNELS-1:0] ch_enable,
    input  logic [CHANNELS-1:0] echo,
    output logic [CHANNELS-1:0] trig,
    output logic                busy,
    output logic                result_valid,
    output logic [c_ch_w-1:0]   result_ch,
    output logic [CNT_W-1:0]    result_count,
    output logic                result_timeout
);

    // One shared timer covers trigger width, echo timeout and holdoff
    localparam int c_tmr_max = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ?
        ((TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES) :
        ((HOLDOFF_CYCLES > TRIG_CYCLES) ? HOLDOFF_CYCLES : TRIG_CYCLES);
    localparam int c_tmr_w = $clog2(c_tmr_max + 1);

    localparam logic [c_tmr_w-1:0]  c_tmr_one   = c_tmr_w'(1);
    localparam logic [c_tmr_w-1:0]  c_trig_last = c_tmr_w'(TRIG_CYCLES - 1);
    localparam logic [c_tmr_w-1:0]  c_tmo_last  = c_tmr_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_tmr_w-1:0]  c_hold_last = c_tmr_w'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_max_echo  = CNT_W'(MAX_ECHO_CYCLES);
    localparam logic [CNT_W-1:0]    c_sat_prev  = CNT_W'(MAX_ECHO_CYCLES - 1);
    localparam logic [CHANNELS-1:0] c_trig_one  = CHANNELS'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIGGER   = 3'd1,
        S_WAIT_ECHO = 3'd2,
        S_COUNT     = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    state_t              r_state;
    logic [CHANNELS-1:0] r_echo_meta;
    logic [CHANNELS-1:0] r_echo_s;
    logic [CHANNELS-1:0] r_en;
    logic [c_ch_w-1:0]   r_ch;
    logic [c_tmr_w-1:0]  r_tmr;
    logic [CNT_W-1:0]    r_count;

    logic [c_ch_w-1:0]   w_first_ch;
    logic [c_ch_w-1:0]   w_next_ch;
    logic                w_has_next;
    logic                w_echo_cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_echo_meta <= '0;
            r_echo_s    <= '0;
        end else begin
            r_echo_meta <= echo;
            r_echo_s    <= r_echo_meta;
        end
    end

    assign w_echo_cur = r_echo_s[r_ch];

    // Descending scans so the lowest qualifying index wins
    always_comb begin
        w_first_ch = '0;
        w_next_ch  = '0;
        w_has_next = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ch_enable[i]) begin
                w_first_ch = c_ch_w'(i);
            end
            if (r_en[i] && (i > int'(r_ch))) begin
                w_next_ch  = c_ch_w'(i);
                w_has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_en           <= '0;
            r_ch           <= '0;
            r_tmr          <= '0;
            r_count        <= '0;
            trig           <= '0;
            busy           <= 1'b0;
            result_valid   <= 1'b0;
            result_ch      <= '0;
            result_count   <= '0;
            result_timeout <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if ((start || continuous) && (|ch_enable)) begin
                        r_en    <= ch_enable;
                        r_ch    <= w_first_ch;
                        trig    <= c_trig_one << w_first_ch;
                        r_tmr   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_TRIGGER;
                    end
                end
                S_TRIGGER: begin
                    if (r_tmr == c_trig_last) begin
                        trig    <= '0;
                        r_tmr   <= '0;
                        r_state <= S_WAIT_ECHO;
                    end else begin
                        r_tmr <= r_tmr + c_tmr_one;
                    end
                end
                S_WAIT_ECHO: begin
                    // The echo-high cycle seen here is already the first counted cycle
                    if (w_echo_cur) begin
                        r_count <= c_cnt_one;
                        r_tmr   <= '0;
                        r_state <= S_COUNT;
                    end else if (r_tmr == c_tmo_last) begin
                        result_valid   <= 1'b1;
                        result_ch      <= r_ch;
                        result_count   <= '0;
                        result_timeout <= 1'b1;
                        r_tmr          <= '0;
                        r_state        <= S_HOLDOFF;
                    end else begin
                        r_tmr <= r_tmr + c_tmr_one;
                    end
                end
                S_COUNT: begin
                    if (!w_echo_cur) begin
                        result_valid   <= 1'b1;
                        result_ch      <= r_ch;
                        result_count   <= r_count;
                        result_timeout <= 1'b0;
                        r_tmr          <= '0;
                        r_state        <= S_HOLDOFF;
                    end else if (r_count == c_sat_prev) begin
                        result_valid   <= 1'b1;
                        result_ch      <= r_ch;
                        result_count   <= c_max_echo;
                        result_timeout <= 1'b1;
                        r_tmr          <= '0;
                        r_state        <= S_HOLDOFF;
                    end else begin
                        r_count <= r_count + c_cnt_one;
                    end
                end
                S_HOLDOFF: begin
                    if (r_tmr == c_hold_last) begin
                        r_tmr <= '0;
                        if (w_has_next) begin
                            r_ch    <= w_next_ch;
                            trig    <= c_trig_one << w_next_ch;
                            r_state <= S_TRIGGER;
                        end else if (continuous && (|ch_enable)) begin
                            r_en    <= ch_enable;
                            r_ch    <= w_first_ch;
                            trig    <= c_trig_one << w_first_ch;
                            r_state <= S_TRIGGER;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_tmr <= r_tmr + c_tmr_one;
                    end
                end
                default: begin
                    trig    <= '0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
